mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM-stage data-memory access unit. Sits directly downstream of the EX/MEM pipeline register.
- Consumes the registered MEM-stage controls, address and store data.
- Runs a req/ack transaction on the data-memory bus, with byte-lane strobes and store-data replication.
- Returns little-endian, extended load data to the MEM/WB path. Holds the pipeline via MemStall while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without ack before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- MemRead_MEM  in  3  load request; nonzero = load.
- MemWrite_MEM  in  2  store request; nonzero = store.
- WriteMemDataLength_MEM  in  3  store size: 1 = byte, 2 = half, 4 = word; other values = word.
- ReadMemExtSignal_MEM  in  4  [3] = 1 sign-extend, 0 zero-extend; [2:0] load size, same encoding as the store size.
- AluResult_MEM  in  32  effective byte address.
- WriteMemData_MEM  in  32  store data, right-aligned.
- dmem_req  out  1  bus request, registered.
- dmem_we  out  1  1 = write, registered.
- dmem_addr  out  32  word address {AluResult[31:2], 2'b00}, registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  32  lane-replicated store data, registered.
- dmem_ack  in  1  bus completion, single-cycle pulse.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- ReadMemData_MEM  out  32  extended load result.
- MemStall  out  1  freeze PC/IF/ID/EX and the EX/MEM register.
- MisalignExc  out  1  one-cycle misalignment flag.
- BusErr  out  1  timeout flag; driven 0 when MEM_TIMEOUT_EN is undefined.

Behaviour:
- Reset, asynchronous on reset_n low: state = IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0.
  - ReadMemData_MEM = 0; MisalignExc, BusErr = 0.
  - MemStall = 0 while reset_n is low.
  - Reset during BUSY abandons the transaction; the next dmem_ack is ignored.
- Op decode:
  - store = MemWrite_MEM != 0.
  - load = MemRead_MEM != 0 and not store; store has priority if both are set.
  - Neither set: no bus activity, MemStall = 0.
- Alignment check:
  - Half requires addr[0] = 0; word requires addr[1:0] = 0.
  - On violation in IDLE: no transaction, MisalignExc = 1 for that cycle, MemStall = 0, ReadMemData_MEM <= 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, aligned load/store present: MemStall = 1 (combinational); the outputs are registered and state <= BUSY.
  - BUSY: dmem_req = 1, MemStall = 1.
  - BUSY on dmem_ack: capture the extended dmem_rdata (loads only) into ReadMemData_MEM; drop dmem_req and dmem_we; state <= DONE.
  - DONE: MemStall = 0 and ReadMemData_MEM is valid, so the pipeline advances at the end of DONE. state <= IDLE.
  - DONE never issues a new request, so the same instruction is never issued twice.
- Minimum occupancy is 3 cycles (IDLE, BUSY, DONE) with MemStall high for 2; each cycle ack is late adds one stall cycle.
- dmem_ack is ignored in IDLE and DONE.
- ReadMemData_MEM holds its value until the next load completes or a misalignment occurs.
- Byte enables:
  - Byte: be = 1 << addr[1:0].
  - Half: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: be = 4'b1111.
- Store data: byte is replicated to all 4 lanes; half is replicated to both halves; word is passed unchanged.
- Load extraction, little-endian:
  - Byte = rdata[8*addr[1:0] +: 8].
  - Half = rdata[16*addr[1] +: 16].
  - Then sign- or zero-extend to 32 bits per ReadMemExtSignal_MEM[3].
- Upstream contract: EX/MEM contents are held constant while MemStall = 1.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: an 8+-bit counter, sized for TIMEOUT_CYCLES, clears on BUSY entry and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without ack: dmem_req <= 0, BusErr = 1 for one cycle, state <= DONE, ReadMemData_MEM <= 0.
- Undefined: no counter; BUSY waits indefinitely; BusErr is tied to 0.

Test Plan:
- Word store: addr 0x100, data 0xDEADBEEF, ack on the first BUSY cycle -> dmem_addr = 0x100, be = 1111, wdata = 0xDEADBEEF, MemStall high for exactly 2 cycles.
- Byte load, signed: addr 0x203, rdata 0x80FF_1234 -> be = 1000, ReadMemData_MEM = 0xFFFFFF80. Unsigned -> 0x00000080.
- Half store at 0x302, data 0x0000ABCD, ack delayed 3 cycles -> be = 1100, wdata = 0xABCDABCD, MemStall high for 5 cycles, a single req transaction.
- Misaligned word load at 0x101 -> MisalignExc pulses 1 cycle, dmem_req stays 0, MemStall = 0, ReadMemData_MEM = 0.
- Reset mid-BUSY: assert reset_n = 0, then ack arrives after release -> dmem_req = 0 immediately, ack ignored, state IDLE, MemStall = 0.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ack -> BusErr pulses after 4 BUSY cycles, then DONE, then IDLE. Undefined -> stall persists.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access: req/ack bus transaction, byte lanes, load extension.
// Latency: 3 cycles minimum (IDLE, BUSY, DONE); each late-ack cycle adds one stall cycle.
// Backpressure: MemStall holds the pipeline while busy; MEM_TIMEOUT_EN adds a BUSY timeout (BusErr).
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [2:0]          MemRead_MEM,
    input  logic [1:0]          MemWrite_MEM,
    input  logic [2:0]          WriteMemDataLength_MEM,
    input  logic [3:0]          ReadMemExtSignal_MEM,
    input  logic [31:0]         AluResult_MEM,
    input  logic [31:0]         WriteMemData_MEM,
    mem_access_stage_if.master  dmem,
    output logic [31:0]         ReadMemData_MEM,
    output logic                MemStall,
    output logic                MisalignExc,
    output logic                BusErr
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    function automatic size_e decode_size(input logic [2:0] enc);
        case (enc)
            3'd1:    return SZ_BYTE;
            3'd2:    return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        is_load_q, is_load_d;
    size_e       ld_size_q, ld_size_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic        ld_sign_q, ld_sign_d;
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buserr_q, buserr_d;
`endif

    logic        is_store, is_load, op_vld, aligned;
    size_e       size_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        stall_c, misalign_c;

    // Store wins when both controls are set.
    assign is_store = |MemWrite_MEM;
    assign is_load  = (|MemRead_MEM) && !is_store;
    assign op_vld   = is_store || is_load;
    assign size_c   = decode_size(is_store ? WriteMemDataLength_MEM : ReadMemExtSignal_MEM[2:0]);

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = WriteMemData_MEM;
        aligned = (AluResult_MEM[1:0] == 2'b00);
        case (size_c)
            SZ_BYTE: begin
                be_c    = 4'b0001 << AluResult_MEM[1:0];
                wdata_c = {4{WriteMemData_MEM[7:0]}};
                aligned = 1'b1;
            end
            SZ_HALF: begin
                be_c    = AluResult_MEM[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteMemData_MEM[15:0]}};
                aligned = !AluResult_MEM[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = dmem.dmem_rdata[{ld_off_q[1], 4'b0000} +: 16];
        case (ld_size_q)
            SZ_BYTE: ld_ext = {{24{ld_sign_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{ld_sign_q & ld_half[15]}}, ld_half};
            default: ld_ext = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        is_load_d  = is_load_q;
        ld_size_d  = ld_size_q;
        ld_off_d   = ld_off_q;
        ld_sign_d  = ld_sign_q;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        buserr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (op_vld && !aligned) begin
                    misalign_c = 1'b1;
                    rdata_d    = '0;
                end else if (op_vld) begin
                    stall_c   = 1'b1;
                    state_d   = BUSY;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {AluResult_MEM[31:2], 2'b00};
                    be_d      = be_c;
                    wdata_d   = is_store ? wdata_c : '0;
                    is_load_d = is_load;
                    ld_size_d = size_c;
                    ld_off_d  = AluResult_MEM[1:0];
                    ld_sign_d = ReadMemExtSignal_MEM[3];
`ifdef MEM_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                    if (is_load_q) rdata_d = ld_ext;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    buserr_d = 1'b1;
                    rdata_d  = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            // DONE lets the pipeline advance and never re-issues the held instruction.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            is_load_q <= 1'b0;
            ld_size_q <= SZ_WORD;
            ld_off_q  <= '0;
            ld_sign_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
            buserr_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            is_load_q <= is_load_d;
            ld_size_q <= ld_size_d;
            ld_off_q  <= ld_off_d;
            ld_sign_q <= ld_sign_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
            buserr_q  <= buserr_d;
`endif
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign ReadMemData_MEM = rdata_q;
    assign MemStall        = reset_n & stall_c;
    assign MisalignExc     = reset_n & misalign_c;
`ifdef MEM_TIMEOUT_EN
    assign BusErr          = buserr_q;
`else
    assign BusErr          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  MemRead_MEM;
    logic [1:0]  MemWrite_MEM;
    logic [2:0]  WriteMemDataLength_MEM;
    logic [3:0]  ReadMemExtSignal_MEM;
    logic [31:0] AluResult_MEM;
    logic [31:0] WriteMemData_MEM;
    logic [31:0] ReadMemData_MEM;
    logic        MemStall;
    logic        MisalignExc;
    logic        BusErr;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .MemRead_MEM            (MemRead_MEM),
        .MemWrite_MEM           (MemWrite_MEM),
        .WriteMemDataLength_MEM (WriteMemDataLength_MEM),
        .ReadMemExtSignal_MEM   (ReadMemExtSignal_MEM),
        .AluResult_MEM          (AluResult_MEM),
        .WriteMemData_MEM       (WriteMemData_MEM),
        .dmem                   (bus.master),
        .ReadMemData_MEM        (ReadMemData_MEM),
        .MemStall               (MemStall),
        .MisalignExc            (MisalignExc),
        .BusErr                 (BusErr)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    int          st, rq;
    logic [31:0] oa, ow, ord;
    logic [3:0]  ob;
    logic        owe, oerr, ok;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic [2:0] mr, input logic [1:0] mw, input logic [2:0] wlen,
                         input logic [3:0] rext, input logic [31:0] a, input logic [31:0] wd);
        MemRead_MEM            = mr;
        MemWrite_MEM           = mw;
        WriteMemDataLength_MEM = wlen;
        ReadMemExtSignal_MEM   = rext;
        AluResult_MEM          = a;
        WriteMemData_MEM       = wd;
    endtask

    // Holds the op until its DONE cycle, acking on BUSY cycle number ack_dly (0 = first).
    task automatic run_op(input logic [2:0] mr, input logic [1:0] mw, input logic [2:0] wlen,
                          input logic [3:0] rext, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_dly);
        int   busy_n;
        logic prev;
        busy_n = 0; prev = 1'b0;
        st = 0; rq = 0; oa = '0; ow = '0; ob = '0; owe = 1'b0; ord = '0; oerr = 1'b0; ok = 1'b0;
        drive(mr, mw, wlen, rext, a, wd);
        for (int c = 0; c < 64 && !ok; c++) begin
            if (bus.dmem_req) begin
                if (busy_n == ack_dly) bus.dmem_ack = 1'b1;
                busy_n++;
            end
            @(negedge clock);
            if (MemStall) st++;
            if (bus.dmem_req && !prev) begin
                rq++;
                oa = bus.dmem_addr; ob = bus.dmem_be; ow = bus.dmem_wdata; owe = bus.dmem_we;
            end
            prev = bus.dmem_req;
            if (st > 0 && !MemStall) begin
                ok = 1'b1; ord = ReadMemData_MEM; oerr = BusErr;
            end
            @(posedge clock); #1;
            bus.dmem_ack = 1'b0;
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h80FF_1234;
        // Op present during reset must not raise MemStall.
        drive(3'd0, 2'd1, 3'd4, 4'd0, 32'h100, 32'hDEADBEEF);
        @(negedge clock);
        check("rst_stall", {31'd0, MemStall}, 32'd0);
        check("rst_req", {31'd0, bus.dmem_req}, 32'd0);
        check("rst_addr", bus.dmem_addr, 32'd0);
        check("rst_be", {28'd0, bus.dmem_be}, 32'd0);
        check("rst_wdata", bus.dmem_wdata, 32'd0);
        check("rst_rdata", ReadMemData_MEM, 32'd0);
        check("rst_misalign", {31'd0, MisalignExc}, 32'd0);
        check("rst_buserr", {31'd0, BusErr}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        run_op(3'd0, 2'd1, 3'd4, 4'd0, 32'h100, 32'hDEADBEEF, 0);
        check("sw_done", {31'd0, ok}, 32'd1);
        check("sw_addr", oa, 32'h100);
        check("sw_be", {28'd0, ob}, 32'hF);
        check("sw_wdata", ow, 32'hDEADBEEF);
        check("sw_we", {31'd0, owe}, 32'd1);
        check("sw_stalls", st, 2);
        check("sw_reqs", rq, 1);

        run_op(3'd1, 2'd0, 3'd0, 4'b1001, 32'h203, 32'd0, 0);
        check("lbs_be", {28'd0, ob}, 32'h8);
        check("lbs_we", {31'd0, owe}, 32'd0);
        check("lbs_data", ord, 32'hFFFFFF80);
        run_op(3'd1, 2'd0, 3'd0, 4'b0001, 32'h203, 32'd0, 0);
        check("lbu_data", ord, 32'h00000080);
        run_op(3'd2, 2'd0, 3'd0, 4'b1010, 32'h202, 32'd0, 0);
        check("lhs_be", {28'd0, ob}, 32'hC);
        check("lhs_data", ord, 32'hFFFF80FF);
        run_op(3'd2, 2'd0, 3'd0, 4'b0010, 32'h200, 32'd0, 1);
        check("lhu_be", {28'd0, ob}, 32'h3);
        check("lhu_data", ord, 32'h00001234);
        check("lhu_stalls", st, 3);

        run_op(3'd0, 2'd2, 3'd2, 4'd0, 32'h302, 32'h0000ABCD, 3);
        check("sh_addr", oa, 32'h300);
        check("sh_be", {28'd0, ob}, 32'hC);
        check("sh_wdata", ow, 32'hABCDABCD);
        check("sh_stalls", st, 5);
        check("sh_reqs", rq, 1);

        // Both controls set: the store must win and leave the load result untouched.
        run_op(3'd1, 2'd3, 3'd1, 4'b0100, 32'h101, 32'h0000005A, 0);
        check("sb_we", {31'd0, owe}, 32'd1);
        check("sb_be", {28'd0, ob}, 32'h2);
        check("sb_wdata", ow, 32'h5A5A5A5A);
        check("sb_addr", oa, 32'h100);
        check("sb_rdata_held", ord, 32'h00001234);

        run_op(3'd1, 2'd0, 3'd0, 4'b0001, 32'h201, 32'd0, 0);
        check("lbu1_data", ord, 32'h00000012);

        drive(3'd1, 2'd0, 3'd0, 4'b0100, 32'h101, 32'd0);
        @(negedge clock);
        check("mis_exc", {31'd0, MisalignExc}, 32'd1);
        check("mis_stall", {31'd0, MemStall}, 32'd0);
        check("mis_req", {31'd0, bus.dmem_req}, 32'd0);
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("mis_exc_end", {31'd0, MisalignExc}, 32'd0);
        check("mis_rdata", ReadMemData_MEM, 32'd0);
        check("mis_req_end", {31'd0, bus.dmem_req}, 32'd0);
        @(posedge clock); #1;

        drive(3'd0, 2'd1, 3'd2, 4'd0, 32'h303, 32'h1111);
        @(negedge clock);
        check("mish_exc", {31'd0, MisalignExc}, 32'd1);
        check("mish_stall", {31'd0, MemStall}, 32'd0);
        @(posedge clock); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check("mish_req", {31'd0, bus.dmem_req}, 32'd0);
        @(posedge clock); #1;

        run_op(3'd1, 2'd0, 3'd0, 4'b0100, 32'h204, 32'd0, 0);
        check("lw_data", ord, 32'h80FF1234);
        check("lw_be", {28'd0, ob}, 32'hF);

`ifdef MEM_TIMEOUT_EN
        run_op(3'd1, 2'd0, 3'd0, 4'b0100, 32'h208, 32'd0, 1000);
        check("to_done", {31'd0, ok}, 32'd1);
        check("to_stalls", st, 5);
        check("to_buserr", {31'd0, oerr}, 32'd1);
        check("to_rdata", ord, 32'd0);
        @(negedge clock);
        check("to_buserr_end", {31'd0, BusErr}, 32'd0);
        check("to_req_end", {31'd0, bus.dmem_req}, 32'd0);
        @(posedge clock); #1;
`else
        drive(3'd1, 2'd0, 3'd0, 4'b0100, 32'h208, 32'd0);
        repeat (20) @(posedge clock);
        #1;
        @(negedge clock);
        check("hang_stall", {31'd0, MemStall}, 32'd1);
        check("hang_req", {31'd0, bus.dmem_req}, 32'd1);
        check("hang_buserr", {31'd0, BusErr}, 32'd0);
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
`endif

        drive(3'd1, 2'd0, 3'd0, 4'b0100, 32'h204, 32'd0);
        @(negedge clock);
        check("rb_issue_stall", {31'd0, MemStall}, 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        check("rb_busy_req", {31'd0, bus.dmem_req}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rb_req_async", {31'd0, bus.dmem_req}, 32'd0);
        check("rb_stall_rst", {31'd0, MemStall}, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        bus.dmem_ack = 1'b1;
        @(negedge clock);
        check("rb_ack_req", {31'd0, bus.dmem_req}, 32'd0);
        check("rb_ack_stall", {31'd0, MemStall}, 32'd0);
        @(posedge clock); #1;
        bus.dmem_ack = 1'b0;
        @(negedge clock);
        check("rb_after_req", {31'd0, bus.dmem_req}, 32'd0);
        check("rb_after_rdata", ReadMemData_MEM, 32'd0);
        @(posedge clock); #1;

        run_op(3'd4, 2'd0, 3'd0, 4'b1001, 32'h202, 32'd0, 0);
        check("rec_done", {31'd0, ok}, 32'd1);
        check("rec_stalls", st, 2);
        check("rec_data", ord, 32'hFFFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
